// File: rtl/md_iter_unit_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
// The EX stage is the master; md_iter_unit is the slave.
interface md_iter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic [2:0]            op_i;
    logic [DATA_WIDTH-1:0] operand1_i;
    logic [DATA_WIDTH-1:0] operand2_i;
    logic                  flush_i;
    logic                  busy_o;
    logic                  done_o;
    logic [DATA_WIDTH-1:0] result_o;

    modport master (
        output start_i, op_i, operand1_i, operand2_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, operand1_i, operand2_i, flush_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/md_iter_unit.sv
// Iterative RV32M multiply/divide unit. A shared 2*DATA_WIDTH accumulator runs
// either unsigned shift-add (multiply) or restoring shift-subtract (divide) on
// operand magnitudes for DATA_WIDTH cycles, then applies sign correction.
module md_iter_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    md_iter_if.slave    bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_e;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    op_e            op_q, op_d;
    logic [2*W-1:0] acc_q, acc_d;       // mul: {high, multiplier}; div: {remainder, dividend/quotient}
    logic [W-1:0]   b_q, b_d;           // mul: multiplicand magnitude; div: divisor magnitude
    logic           neg_res_q, neg_res_d; // negate product (mul) or quotient (div)
    logic           neg_rem_q, neg_rem_d; // remainder follows dividend sign
    logic           special_q, special_d; // result preloaded into acc low word
    logic [W-1:0]   result_q, result_d;
    logic           done_q, done_d;

    // Launch-time operand preparation
    op_e            op_in;
    logic           is_div, sign_a, sign_b, a_neg, b_neg, div_zero, div_ovf, special;
    logic [W-1:0]   mag_a, mag_b, special_res;

    // One iteration of each algorithm
    logic [W:0]     mul_sum, rem_sh, div_diff;
    logic [2*W-1:0] mul_next, div_next;
    logic           div_ge;

    // Sign-corrected results for FINISH
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo, rem, fin_res;

    // State register
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; flush returns to IDLE from any active state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.start_i && !bus.flush_i) state_d = special ? S_FINISH : S_CALC;
            S_CALC:   if (bus.flush_i) state_d = S_IDLE;
                      else if (cnt_q == CW'(W - 1)) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Operand magnitudes, sign flags and special-case detection at launch
    always_comb begin
        op_in       = op_e'(bus.op_i);
        is_div      = bus.op_i[2];
        sign_a      = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
        sign_b      = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        a_neg       = sign_a && bus.operand1_i[W-1];
        b_neg       = sign_b && bus.operand2_i[W-1];
        mag_a       = a_neg ? -bus.operand1_i : bus.operand1_i;
        mag_b       = b_neg ? -bus.operand2_i : bus.operand2_i;
        div_zero    = is_div && (bus.operand2_i == '0);
        div_ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                      (bus.operand1_i == {1'b1, {(W-1){1'b0}}}) && (bus.operand2_i == '1);
        special     = div_zero || div_ovf;
        // op_i[1] separates REM/REMU from DIV/DIVU
        if (div_zero) special_res = bus.op_i[1] ? bus.operand1_i : '1;
        else          special_res = bus.op_i[1] ? '0 : {1'b1, {(W-1){1'b0}}};
    end

    // Single iteration of shift-add and restoring shift-subtract
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {mul_sum, acc_q[W-1:1]};
        rem_sh   = acc_q[2*W-1:W-1];
        div_diff = rem_sh - {1'b0, b_q};
        div_ge   = !div_diff[W];
        div_next = {div_ge ? div_diff[W-1:0] : rem_sh[W-1:0], acc_q[W-2:0], div_ge};
    end

    // Sign correction and result selection
    always_comb begin
        prod = neg_res_q ? -acc_q : acc_q;
        quo  = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem  = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        if (special_q) fin_res = acc_q[W-1:0];
        else begin
            unique case (op_q)
                OP_MUL:           fin_res = prod[W-1:0];
                OP_DIV, OP_DIVU:  fin_res = quo;
                OP_REM, OP_REMU:  fin_res = rem;
                default:          fin_res = prod[2*W-1:W];
            endcase
        end
    end

    // Datapath and output register updates
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        b_d       = b_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        special_d = special_q;
        result_d  = result_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: if (bus.start_i && !bus.flush_i) begin
                op_d      = op_in;
                cnt_d     = '0;
                neg_res_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                special_d = special;
                b_d       = is_div ? mag_b : mag_a;
                if (special)     acc_d = {{W{1'b0}}, special_res};
                else if (is_div) acc_d = {{W{1'b0}}, mag_a};
                else             acc_d = {{W{1'b0}}, mag_b};
            end
            S_CALC: if (!bus.flush_i) begin
                cnt_d = cnt_q + CW'(1);
                acc_d = op_q[2] ? div_next : mul_next;
            end
            S_FINISH: if (!bus.flush_i) begin
                result_d = fin_res;
                done_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            op_q      <= OP_MUL;
            acc_q     <= '0;
            b_q       <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            special_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            special_q <= special_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy_o   = (state_q != S_IDLE);
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
endmodule

// File: tb/tb_md_iter_unit.sv
// Directed self-checking bench for md_iter_unit with hand-computed expectations.
module tb_md_iter_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    md_iter_if #(.DATA_WIDTH(32)) bus ();

    md_iter_unit #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Drive a one-cycle start; returns at the falling edge after the start edge E0
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.op_i       = op;
        bus.operand1_i = a;
        bus.operand2_i = b;
        bus.start_i    = 1'b1;
        @(negedge clk);
        bus.start_i    = 1'b0;
    endtask

    // Wait (bounded) for done; lat counts edges after E0, -1 on timeout
    task automatic wait_done(input int elapsed, output logic [31:0] res, output int lat);
        lat = -1;
        res = 32'hDEAD_BEEF;
        for (int n = elapsed + 1; n <= elapsed + 60; n++) begin
            @(posedge clk);
            #1;
            if (bus.done_o === 1'b1) begin
                lat = n;
                res = bus.result_o;
                break;
            end
        end
    endtask

    // Launch an op and compare its result and latency
    task automatic run_and_check(input string name, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int          lat;
        launch(op, a, b);
        wait_done(0, res, lat);
        vectors++;
        if (res !== exp) begin
            miscompares++;
            $display("FAIL %s result: got %h expected %h", name, res, exp);
        end
        vectors++;
        if (lat !== exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b expected 0", bus.busy_o); end
        vectors++;
        if (bus.done_o !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b expected 0", bus.done_o); end
        vectors++;
        if (bus.result_o !== 32'h0) begin miscompares++; $display("FAIL reset result: got %h expected 0", bus.result_o); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic [31:0] res;
        int          lat;
        launch(3'd0, 32'h0000_0007, 32'hFFFF_FFFD);
        vectors++;
        if (bus.busy_o !== 1'b1) begin miscompares++; $display("FAIL mul busy after start: got %b expected 1", bus.busy_o); end
        wait_done(0, res, lat);
        vectors++;
        if (res !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL mul result: got %h expected ffffffeb", res); end
        vectors++;
        if (lat !== 33) begin miscompares++; $display("FAIL mul latency: got %0d expected 33", lat); end
        vectors++;
        if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL mul busy at done: got %b expected 0", bus.busy_o); end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.done_o !== 1'b0) begin miscompares++; $display("FAIL mul done pulse width: got %b expected 0", bus.done_o); end
        vectors++;
        if (bus.result_o !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL mul result hold: got %h expected ffffffeb", bus.result_o); end
        run_and_check("mulh", 3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    endtask

    task automatic test_mul_high();
        run_and_check("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_and_check("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    endtask

    task automatic test_div();
        run_and_check("div",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_and_check("rem",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_and_check("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);
        run_and_check("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    endtask

    task automatic test_special();
        run_and_check("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_and_check("rem_by0",  3'd6, 32'd5, 32'd0, 32'd5, 1);
        run_and_check("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        run_and_check("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    endtask

    task automatic test_flush();
        int done_seen = 0;
        launch(3'd4, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL flush busy: got %b expected 0", bus.busy_o); end
        vectors++;
        if (bus.result_o !== 32'h8000_0000) begin miscompares++; $display("FAIL flush result kept: got %h expected 80000000", bus.result_o); end
        @(negedge clk);
        bus.flush_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_o === 1'b1) done_seen++;
        end
        vectors++;
        if (done_seen !== 0) begin miscompares++; $display("FAIL flush done count: got %0d expected 0", done_seen); end
    endtask

    task automatic test_flush_start_idle();
        @(negedge clk);
        bus.op_i       = 3'd0;
        bus.operand1_i = 32'd3;
        bus.operand2_i = 32'd4;
        bus.start_i    = 1'b1;
        bus.flush_i    = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL flush_with_start busy: got %b expected 0", bus.busy_o); end
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
    endtask

    task automatic test_start_ignored();
        logic [31:0] res;
        int          lat;
        launch(3'd5, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.op_i       = 3'd0;
        bus.operand1_i = 32'd3;
        bus.operand2_i = 32'd4;
        bus.start_i    = 1'b1;
        @(negedge clk);
        bus.start_i    = 1'b0;
        wait_done(5, res, lat);
        vectors++;
        if (res !== 32'd14) begin miscompares++; $display("FAIL start_while_busy result: got %h expected 0000000e", res); end
        vectors++;
        if (lat !== 33) begin miscompares++; $display("FAIL start_while_busy latency: got %0d expected 33", lat); end
    endtask

    task automatic test_reset_mid();
        launch(3'd0, 32'h0000_0007, 32'hFFFF_FFFD);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL mid_reset busy: got %b expected 0", bus.busy_o); end
        vectors++;
        if (bus.done_o !== 1'b0) begin miscompares++; $display("FAIL mid_reset done: got %b expected 0", bus.done_o); end
        vectors++;
        if (bus.result_o !== 32'h0) begin miscompares++; $display("FAIL mid_reset result: got %h expected 0", bus.result_o); end
        @(negedge clk);
        rst_n = 1'b1;
        run_and_check("mul_after_reset", 3'd0, 32'd3, 32'd4, 32'd12, 33);
    endtask

    initial begin
        bus.start_i    = 1'b0;
        bus.flush_i    = 1'b0;
        bus.op_i       = 3'd0;
        bus.operand1_i = 32'h0;
        bus.operand2_i = 32'h0;
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_special();
        test_flush();
        test_flush_start_idle();
        test_start_ignored();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
